// File: rtl/rx_frame_sequencer_pkg.sv
// Shared definitions for the UART receive sequencer: state encoding, widths,
// parity-sense constants and the frame-length helper.
package rx_frame_sequencer_pkg;

  localparam int CNT_W_DEF   = 18;
  localparam int FRAME_W_DEF = 10;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Sampled bits after the start bit, stop bit included: 8..10.
  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    return 4'd8 + {3'b000, eight} + {3'b000, pen};
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time timer: counts up from 0 while enabled and ticks on the last count
// of either a half bit or a full bit, then wraps to 0.
module rx_bit_timer
  import rx_frame_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             half_sel,
  input  logic [CNT_W-1:0] baud_count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] bit_len;
  logic [CNT_W-1:0] target;

  // Clamp first so that target-1 can never wrap below zero.
  always_comb begin
    bit_len = (baud_count < TWO) ? TWO : baud_count;
    target  = half_sel ? (bit_len >> 1) : bit_len;
  end

  assign tick = enable && !clear && (count == target - ONE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/rx_frame_sequencer.sv
// UART receive sequencer: start-bit detect, centre sampling, character
// assembly and parity/framing error flags.
//   state | meaning
//   IDLE  | line idle, waiting for rx low
//   START | half-bit wait, start bit re-checked at its centre
//   DATA  | one sample per full bit: data, optional parity, stop
//   DONE  | align frame, publish rx_data/perr/ferr, pulse rx_rdy
module rx_frame_sequencer
  import rx_frame_sequencer_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             rx,
  input  logic [CNT_W-1:0] baud_count,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  output logic [7:0]       rx_data,
  output logic             rx_rdy,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  state_t             state;
  logic [CNT_W-1:0]   baud_q;
  logic               eight_q;
  logic               pen_q;
  logic               ohel_q;
  logic [3:0]         idx;
  logic [FRAME_W-1:0] shreg;
  logic               tick;

  logic [3:0]         n_bits;
  logic [3:0]         shamt;
  logic [3:0]         par_idx;
  logic [FRAME_W-1:0] aligned;
  logic [7:0]         data_w;
  logic               p;
  logic               perr_w;
  logic               ferr_w;

  rx_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .enable     ((state == ST_START) || (state == ST_DATA)),
    .clear      (state == ST_IDLE),
    .half_sel   (state == ST_START),
    .baud_count (baud_q),
    .tick       (tick)
  );

  // Samples enter at the MSB, so after N shifts the frame sits in the top N bits.
  always_comb begin
    n_bits  = frame_len(eight_q, pen_q);
    shamt   = 4'(FRAME_W) - n_bits;
    par_idx = 4'd7 + {3'b000, eight_q};
    aligned = shreg >> shamt;
    data_w  = aligned[7:0] & (eight_q ? 8'hFF : 8'h7F);
    p       = (^data_w) ^ (pen_q & aligned[par_idx]);
    perr_w  = pen_q & ((ohel_q == PAR_ODD) ? ~p : p);
    ferr_w  = ~shreg[FRAME_W-1];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      baud_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      idx     <= '0;
      shreg   <= '0;
      rx_data <= 8'h00;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx) begin
            state   <= ST_START;
            busy    <= 1'b1;
            baud_q  <= baud_count;
            eight_q <= eight;
            pen_q   <= pen;
            ohel_q  <= ohel;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
              idx   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg <= {rx, shreg[FRAME_W-1:1]};
            idx   <= idx + 4'd1;
            if (idx == n_bits - 4'd1) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          rx_data <= data_w;
          perr    <= perr_w;
          ferr    <= ferr_w;
          rx_rdy  <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench for rx_frame_sequencer: frames are serialised on rx, the
// expected character/flags are queued and checked on each rx_rdy pulse.
module tb_rx_frame_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        rx;
  logic [17:0] baud_count;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        perr;
  logic        ferr;
  logic        busy;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          last_rdy_cyc = -1;
  logic [9:0]  exp_q[$];

  rx_frame_sequencer dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .rx         (rx),
    .baud_count (baud_count),
    .eight      (eight),
    .pen        (pen),
    .ohel       (ohel),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .perr       (perr),
    .ferr       (ferr),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic monitor();
    logic       prev = 1'b0;
    logic [9:0] e;
    forever begin
      @(negedge Clk);
      if (rx_rdy) begin
        last_rdy_cyc = cyc;
        vectors++;
        if (prev) begin
          miscompares++;
          $display("FAIL rdy_width: rx_rdy high on consecutive cycles at cycle %0d", cyc);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rdy: rx_rdy with no frame pending, rx_data=%h cycle %0d", rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          vectors += 2;
          if (rx_data !== e[9:2]) begin
            miscompares++;
            $display("FAIL rx_data: got %h expected %h", rx_data, e[9:2]);
          end
          if ({perr, ferr} !== e[1:0]) begin
            miscompares++;
            $display("FAIL flags: got perr=%b ferr=%b expected perr=%b ferr=%b", perr, ferr, e[1], e[0]);
          end
        end
      end
      prev = rx_rdy;
    end
  endtask

  // Serialise one frame; gap=0 leaves the line for the next frame to start right after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic e8, input logic pn, input logic od,
                            input logic flip, input logic stop, input logic [17:0] baud,
                            input logic scramble, input int gap, output int t0);
    int         period;
    int         nb;
    int         dbits;
    logic [7:0] dm;
    logic       par;
    logic [11:0] line;
    period = (baud < 18'd2) ? 2 : int'(baud);
    dbits  = e8 ? 8 : 7;
    dm     = d & (e8 ? 8'hFF : 8'h7F);
    par    = (^dm) ^ od ^ flip;
    line   = '0;
    line[0] = 1'b0;
    for (int i = 0; i < dbits; i++) line[1+i] = dm[i];
    nb = 1 + dbits;
    if (pn) begin
      line[nb] = par;
      nb++;
    end
    line[nb] = stop;
    nb++;
    eight = e8; pen = pn; ohel = od; baud_count = baud;
    exp_q.push_back({dm, pn & flip, ~stop});
    @(negedge Clk);
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = line[i];
      if (scramble && i == 1) begin
        eight = ~e8; pen = ~pn; ohel = ~od; baud_count = 18'd37;
      end
      repeat (period) @(negedge Clk);
    end
    rx = 1'b1;
    if (gap > 0) begin
      repeat (2 * period + gap) @(negedge Clk);
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL missing_rdy: %0d frame(s) never delivered, expected 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; rx = 1'b1; baud_count = 18'd16; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({rx_data, rx_rdy, perr, ferr, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h rdy=%b perr=%b ferr=%b busy=%b expected all 0",
               rx_data, rx_rdy, perr, ferr, busy);
    end
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    vectors++;
    if ({rx_rdy, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b expected 0 0", rx_rdy, busy);
    end
  endtask

  task automatic test_8n1();
    int t0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd16, 1'b1, 8, t0);
    vectors++;
    if (last_rdy_cyc - t0 - 1 !== 153) begin
      miscompares++;
      $display("FAIL rdy_latency_b16: got edge %0d expected 153", last_rdy_cyc - t0 - 1);
    end
  endtask

  task automatic test_parity();
    int t0;
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 18'd16, 1'b0, 8, t0);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd16, 1'b0, 8, t0);
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
    send_frame(8'hD3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
  endtask

  task automatic test_framing();
    int t0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 18'd16, 1'b0, 8, t0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
  endtask

  task automatic test_back_to_back();
    int t0;
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 0, t0);
    send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
  endtask

  task automatic test_false_start();
    baud_count = 18'd16; eight = 1'b1; pen = 1'b0;
    @(negedge Clk);
    rx = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge Clk);
      #1;
      vectors++;
      if (busy !== (k < 8)) begin
        miscompares++;
        $display("FAIL glitch_busy: after edge %0d got %b expected %b", k, busy, (k < 8));
      end
      if (k == 3) rx = 1'b1;
    end
    repeat (40) @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int t0;
    baud_count = 18'd16; eight = 1'b1; pen = 1'b0;
    @(negedge Clk);
    rx = 1'b0;
    repeat (8 + 16 * 4 + 6) @(negedge Clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_mid_frame: got %b expected 1", busy);
    end
    Rst = 1'b0;
    #1;
    vectors++;
    if ({rx_data, rx_rdy, perr, ferr, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got data=%h rdy=%b perr=%b ferr=%b busy=%b expected all 0",
               rx_data, rx_rdy, perr, ferr, busy);
    end
    rx = 1'b1;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd16, 1'b0, 8, t0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'd1, 1'b0, 8, t0);
    vectors++;
    if (last_rdy_cyc - t0 - 1 !== 20) begin
      miscompares++;
      $display("FAIL rdy_latency_b1: got edge %0d expected 20", last_rdy_cyc - t0 - 1);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_back_to_back();
    test_false_start();
    test_reset_mid();
    repeat (4) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
